// File: rtl/ad5676_dac_timing_ctrl_pkg.sv
// Shared types and constants for the AD5676 DAC n_cs timing controller.
package ad5676_dac_pkg;

  localparam int NCS_W = 5;

  typedef logic [NCS_W-1:0] ncs_t;

  // Slowest n_cs high time; safe for any SPI clock until a real value is committed.
  localparam ncs_t NCS_SAFE_DEFAULT = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CALC,
    S_WAIT_SPI,
    S_COMMIT,
    S_HOLD,
    S_ERROR
  } state_t;

  function automatic logic is_busy_state(input state_t s);
    return (s == S_SETTLE) || (s == S_CALC) || (s == S_WAIT_SPI);
  endfunction

endpackage

// File: rtl/ad5676_dac_timing_ctrl_if.sv
// Start/result handshake between the timing controller and the n_cs calculator.
interface ad5676_dac_timing_ctrl_if;
  import ad5676_dac_pkg::*;

  logic calc;
  logic calc_done;
  logic calc_lock_viol;
  ncs_t calc_n_cs_high_time;

  modport master (
    output calc,
    input  calc_done,
    input  calc_lock_viol,
    input  calc_n_cs_high_time
  );

  modport slave (
    input  calc,
    output calc_done,
    output calc_lock_viol,
    output calc_n_cs_high_time
  );

endinterface

// File: rtl/ad5676_dac_timing_ctrl_freq_settle_detect.sv
// Tracks a reference copy of the SPI clock frequency and counts how long it has held steady.
module freq_settle_detect #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] freq,
  input  logic        load,
  input  logic        count,
  output logic        settled,
  output logic        changed
);

  localparam logic [15:0] LAST = 16'(SETTLE_CYCLES - 1);

  logic [31:0] freq_ref;
  logic [15:0] cnt;

  assign changed = (freq != freq_ref);
  assign settled = count && !changed && (cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      freq_ref <= '0;
      cnt      <= '0;
    end else if (load) begin
      freq_ref <= freq;
      cnt      <= '0;
    end else if (count) begin
      if (changed) begin
        freq_ref <= freq;
        cnt      <= '0;
      end else if (cnt != LAST) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/ad5676_dac_timing_ctrl.sv
// Sequences the AD5676 n_cs timing calculator and commits its result to the SPI core.
// Optional calculator watchdog: define DAC_TIMING_CTRL_TIMEOUT_EN.
module ad5676_dac_timing_ctrl
  import ad5676_dac_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            en,
  input  logic [31:0]                     spi_clk_freq_hz,
  input  logic                            spi_busy,
  ad5676_dac_timing_ctrl_if.master        calc_bus,
  output ncs_t                            n_cs_high_time,
  output logic                            cfg_valid,
  output logic                            cfg_update,
  output logic                            busy,
  output logic                            retry_err,
  output logic                            timeout_err
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535 ||
      MAX_RETRIES < 0 || MAX_RETRIES > 254 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("ad5676_dac_timing_ctrl: parameter out of range");
  end

  state_t     state, state_nxt;
  ncs_t       shadow, shadow_nxt;
  ncs_t       ncs_nxt;
  logic       valid_nxt;
  logic       update_nxt;
  logic [7:0] retry_cnt, retry_cnt_nxt;
  logic       retry_err_nxt;
  logic       load_ref;
  logic       settled;
  logic       freq_changed;

  freq_settle_detect #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk     (clk),
    .resetn  (resetn),
    .freq    (spi_clk_freq_hz),
    .load    (load_ref),
    .count   (state == S_SETTLE),
    .settled (settled),
    .changed (freq_changed)
  );

`ifdef DAC_TIMING_CTRL_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        timeout_err_nxt;

  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt     <= (state == S_CALC) ? tmo_cnt + 16'd1 : '0;
      timeout_err <= timeout_err_nxt;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // NOTE: every variable driven here gets its hold value first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nxt     = state;
    shadow_nxt    = shadow;
    ncs_nxt       = n_cs_high_time;
    valid_nxt     = cfg_valid;
    update_nxt    = 1'b0;
    retry_cnt_nxt = retry_cnt;
    retry_err_nxt = retry_err;
`ifdef DAC_TIMING_CTRL_TIMEOUT_EN
    timeout_err_nxt = timeout_err;
`endif

    if (!en) begin
      state_nxt     = S_IDLE;
      valid_nxt     = 1'b0;
      retry_cnt_nxt = '0;
      retry_err_nxt = 1'b0;
`ifdef DAC_TIMING_CTRL_TIMEOUT_EN
      timeout_err_nxt = 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: state_nxt = S_SETTLE;

        S_SETTLE: if (settled) state_nxt = S_CALC;

        // A lock violation outranks a simultaneous done: the result is stale.
        S_CALC: begin
          if (calc_bus.calc_lock_viol) begin
            retry_cnt_nxt = retry_cnt + 8'd1;
            if (retry_cnt == 8'(MAX_RETRIES)) begin
              state_nxt     = S_ERROR;
              retry_err_nxt = 1'b1;
              valid_nxt     = 1'b0;
            end else begin
              state_nxt = S_SETTLE;
            end
          end else if (calc_bus.calc_done) begin
            shadow_nxt = calc_bus.calc_n_cs_high_time;
            state_nxt  = S_WAIT_SPI;
          end
`ifdef DAC_TIMING_CTRL_TIMEOUT_EN
          else if (tmo_hit) begin
            state_nxt       = S_ERROR;
            timeout_err_nxt = 1'b1;
            valid_nxt       = 1'b0;
          end
`endif
        end

        S_WAIT_SPI: begin
          if (freq_changed)   state_nxt = S_SETTLE;
          else if (!spi_busy) state_nxt = S_COMMIT;
        end

        S_COMMIT: begin
          ncs_nxt       = shadow;
          valid_nxt     = 1'b1;
          update_nxt    = 1'b1;
          retry_cnt_nxt = '0;
          state_nxt     = S_HOLD;
        end

        S_HOLD: begin
          if (freq_changed) begin
            valid_nxt = 1'b0;
            state_nxt = S_SETTLE;
          end
        end

        S_ERROR: valid_nxt = 1'b0;

        default: state_nxt = S_IDLE;
      endcase
    end

    // Each fresh settle epoch starts from the current frequency with a zero count.
    load_ref = (state == S_IDLE) ||
               ((state_nxt == S_SETTLE) && (state != S_SETTLE));
  end

  // NOTE: shadow is a single register, not a memory, so it is reset like any
  // other flop to keep the post-reset state fully defined.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      shadow         <= NCS_SAFE_DEFAULT;
      n_cs_high_time <= NCS_SAFE_DEFAULT;
      cfg_valid      <= 1'b0;
      cfg_update     <= 1'b0;
      calc_bus.calc  <= 1'b0;
      busy           <= 1'b0;
      retry_cnt      <= '0;
      retry_err      <= 1'b0;
    end else begin
      state          <= state_nxt;
      shadow         <= shadow_nxt;
      n_cs_high_time <= ncs_nxt;
      cfg_valid      <= valid_nxt;
      cfg_update     <= update_nxt;
      calc_bus.calc  <= (state_nxt == S_CALC);
      busy           <= is_busy_state(state_nxt);
      retry_cnt      <= retry_cnt_nxt;
      retry_err      <= retry_err_nxt;
    end
  end

endmodule
